// File: rtl/arithmetic_encoder.sv
// rtl/arithmetic_encoder.sv - static uniform-model arithmetic encoder emitting 32-bit LSB-first code words
module arithmetic_encoder #(
  parameter int ENCODER_PRECISION      = 16,
  parameter int ENCODER_NUM_OF_SYMBOLS = 257,
  parameter int ENCODER_EOF_SYMBOL     = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] inputBytes,
  input  logic [2:0]  validInputBytes,
  input  logic        lastInput,
  input  logic        newBytesProvided,
  input  logic        readSuccess,
  output logic        idle,
  output logic        newBytesRequested,
  output logic        resultReady,
  output logic [5:0]  validOutputBits,
  output logic [31:0] out
);
  localparam int P  = ENCODER_PRECISION;
  localparam int PW = P + 8;
  localparam int SW = $clog2(ENCODER_NUM_OF_SYMBOLS);
  localparam logic [P-1:0]  WHOLE          = P'(1 << (P - 1));
  localparam logic [P-1:0]  HALF           = P'(1 << (P - 2));
  localparam logic [P-1:0]  QUARTER        = P'(1 << (P - 3));
  localparam logic [P-1:0]  THREE_QUARTERS = P'(3 << (P - 3));
  localparam logic [SW:0]   DIVISOR        = (SW + 1)'(ENCODER_NUM_OF_SYMBOLS);
  localparam logic [SW-1:0] EOF_SYM        = SW'(ENCODER_EOF_SYMBOL);

  typedef enum logic [3:0] {
    IDLE, LOAD_SYMBOL, MULTIPLY, DIVIDE, UPDATE, RESCALE, EMIT, FLUSH,
    WAIT_FOR_READ_ACK, READ_ACKNOWLEDGED, WAIT_FOR_NEW_BYTES, NEW_BYTES_PROVIDED
  } state_t;

  state_t         state_q, state_d, ret_q, ret_d;
  logic [P-1:0]   a_q, a_d, b_q, b_d, s_q, s_d;
  logic [4:0]     bit_ptr_q, bit_ptr_d, div_cnt_q, div_cnt_d;
  logic [2:0]     byte_ptr_q, byte_ptr_d, count_q, count_d;
  logic [31:0]    word_q, word_d, out_q, out_d;
  logic           last_q, last_d, emit_bit_q, emit_bit_d, emit_first_q, emit_first_d;
  logic           flushing_q, flushing_d, ready_q, ready_d, req_q, req_d;
  logic [SW-1:0]  sym_q, sym_d, rem_b_q, rem_b_d, rem_e_q, rem_e_d;
  logic [PW-1:0]  div_b_q, div_b_d, div_e_q, div_e_d;
  logic [5:0]     valid_q, valid_d;
  logic [P-1:0]   span, s_inc;
  logic [7:0]     cur_byte;
  logic           emit_cur, more;

  // One restoring-division step; the dividend register doubles as the quotient register.
  function automatic logic [SW+PW-1:0] div_step(input logic [SW-1:0] rem, input logic [PW-1:0] dvd);
    logic [SW:0] trial;
    trial = {rem, dvd[PW-1]};
    if (trial >= DIVISOR) return {SW'(trial - DIVISOR), dvd[PW-2:0], 1'b1};
    return {trial[SW-1:0], dvd[PW-2:0], 1'b0};
  endfunction

  function automatic logic [2:0] clamp_count(input logic [2:0] v);
    return (v > 3'd4) ? 3'd4 : v;
  endfunction

  assign span     = b_q - a_q;
  assign s_inc    = (&s_q) ? s_q : s_q + 1'b1;
  assign cur_byte = word_q[{byte_ptr_q[1:0], 3'b000} +: 8];
  assign emit_cur = emit_first_q ? emit_bit_q : ~emit_bit_q;
  assign more     = emit_first_q ? (s_q != '0) : (s_q != P'(1));

  always_comb begin
    state_d = state_q;   ret_d = ret_q;
    a_d = a_q;           b_d = b_q;           s_d = s_q;
    bit_ptr_d = bit_ptr_q; byte_ptr_d = byte_ptr_q; div_cnt_d = div_cnt_q;
    word_d = word_q;     count_d = count_q;   last_d = last_q;
    out_d = out_q;       valid_d = valid_q;   ready_d = ready_q;  req_d = req_q;
    emit_bit_d = emit_bit_q; emit_first_d = emit_first_q; flushing_d = flushing_q;
    sym_d = sym_q;       rem_b_d = rem_b_q;   rem_e_d = rem_e_q;
    div_b_d = div_b_q;   div_e_d = div_e_q;
    case (state_q)
      IDLE: begin
        a_d = '0; b_d = WHOLE; s_d = '0; bit_ptr_d = '0; byte_ptr_d = '0;
        out_d = '0; valid_d = '0; flushing_d = 1'b0;
        if (start) begin
          word_d = inputBytes; count_d = clamp_count(validInputBytes); last_d = lastInput;
          state_d = LOAD_SYMBOL;
        end
      end
      LOAD_SYMBOL: begin
        if (byte_ptr_q < count_q) begin
          sym_d = SW'(cur_byte); state_d = MULTIPLY;
        end else if (last_q) begin
          sym_d = EOF_SYM; state_d = MULTIPLY;
        end else begin
          req_d = 1'b1; state_d = WAIT_FOR_NEW_BYTES;
        end
      end
      MULTIPLY: begin
        div_b_d = PW'(span) * PW'(sym_q);
        div_e_d = PW'(span) * PW'(sym_q) + PW'(span);
        rem_b_d = '0; rem_e_d = '0; div_cnt_d = '0;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        {rem_b_d, div_b_d} = div_step(rem_b_q, div_b_q);
        {rem_e_d, div_e_d} = div_step(rem_e_q, div_e_q);
        div_cnt_d = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'(PW - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        b_d = P'(PW'(a_q) + div_e_q);
        a_d = P'(PW'(a_q) + div_b_q);
        if (sym_q != EOF_SYM) byte_ptr_d = byte_ptr_q + 3'd1;
        state_d = RESCALE;
      end
      RESCALE: begin
        if (b_q < HALF) begin
          emit_bit_d = 1'b0; emit_first_d = 1'b1;
          a_d = a_q << 1; b_d = b_q << 1; state_d = EMIT;
        end else if (a_q > HALF) begin
          emit_bit_d = 1'b1; emit_first_d = 1'b1;
          a_d = (a_q - HALF) << 1; b_d = (b_q - HALF) << 1; state_d = EMIT;
        end else if (a_q > QUARTER && b_q < THREE_QUARTERS) begin
          s_d = s_inc; a_d = (a_q - QUARTER) << 1; b_d = (b_q - QUARTER) << 1;
        end else begin
          state_d = (sym_q == EOF_SYM) ? FLUSH : LOAD_SYMBOL;
        end
      end
      EMIT: begin
        out_d[bit_ptr_q] = emit_cur;
        if (!emit_first_q) s_d = s_q - 1'b1;
        emit_first_d = 1'b0;
        bit_ptr_d = bit_ptr_q + 5'd1;
        // A full word leaves bitPtr at 0, so a flush ending here needs no trailing word.
        if (bit_ptr_q == 5'd31) begin
          valid_d = 6'd32; ready_d = 1'b1;
          ret_d = more ? EMIT : (flushing_q ? IDLE : RESCALE);
          state_d = WAIT_FOR_READ_ACK;
        end else if (!more) begin
          if (flushing_q) begin
            valid_d = 6'(bit_ptr_q) + 6'd1; ready_d = 1'b1;
            ret_d = IDLE; state_d = WAIT_FOR_READ_ACK;
          end else begin
            state_d = RESCALE;
          end
        end
      end
      FLUSH: begin
        s_d = s_inc; emit_bit_d = (a_q > QUARTER); emit_first_d = 1'b1;
        flushing_d = 1'b1; state_d = EMIT;
      end
      WAIT_FOR_READ_ACK: begin
        if (readSuccess) begin
          ready_d = 1'b0; out_d = '0; bit_ptr_d = '0; state_d = READ_ACKNOWLEDGED;
        end
      end
      READ_ACKNOWLEDGED: if (!readSuccess) state_d = ret_q;
      WAIT_FOR_NEW_BYTES: begin
        if (newBytesProvided) begin
          word_d = inputBytes; count_d = clamp_count(validInputBytes); last_d = lastInput;
          req_d = 1'b0; byte_ptr_d = '0; state_d = NEW_BYTES_PROVIDED;
        end
      end
      NEW_BYTES_PROVIDED: if (!newBytesProvided) state_d = LOAD_SYMBOL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;     ret_q <= IDLE;
      a_q <= '0;           b_q <= WHOLE;        s_q <= '0;
      bit_ptr_q <= '0;     byte_ptr_q <= '0;    div_cnt_q <= '0;
      word_q <= '0;        count_q <= '0;       last_q <= 1'b0;
      out_q <= '0;         valid_q <= '0;       ready_q <= 1'b0;   req_q <= 1'b0;
      emit_bit_q <= 1'b0;  emit_first_q <= 1'b0; flushing_q <= 1'b0;
      sym_q <= '0;         rem_b_q <= '0;       rem_e_q <= '0;
      div_b_q <= '0;       div_e_q <= '0;
    end else begin
      state_q <= state_d;  ret_q <= ret_d;
      a_q <= a_d;          b_q <= b_d;          s_q <= s_d;
      bit_ptr_q <= bit_ptr_d; byte_ptr_q <= byte_ptr_d; div_cnt_q <= div_cnt_d;
      word_q <= word_d;    count_q <= count_d;  last_q <= last_d;
      out_q <= out_d;      valid_q <= valid_d;  ready_q <= ready_d; req_q <= req_d;
      emit_bit_q <= emit_bit_d; emit_first_q <= emit_first_d; flushing_q <= flushing_d;
      sym_q <= sym_d;      rem_b_q <= rem_b_d;  rem_e_q <= rem_e_d;
      div_b_q <= div_b_d;  div_e_q <= div_e_d;
    end
  end

  assign idle              = (state_q == IDLE);
  assign newBytesRequested = req_q;
  assign resultReady       = ready_q;
  assign validOutputBits   = valid_q;
  assign out               = out_q;
endmodule

// File: tb/tb_arithmetic_encoder.sv
// tb/tb_arithmetic_encoder.sv - directed-vector and golden-model bench for arithmetic_encoder
module tb_arithmetic_encoder;
  logic        clk = 1'b0;
  logic        rstn, start, lastInput, newBytesProvided, readSuccess;
  logic [31:0] inputBytes;
  logic [2:0]  validInputBytes;
  logic        idle, newBytesRequested, resultReady;
  logic [5:0]  validOutputBits;
  logic [31:0] out;

  always #5 clk = ~clk;

  arithmetic_encoder dut (
    .clk(clk), .rstn(rstn), .start(start), .inputBytes(inputBytes),
    .validInputBytes(validInputBytes), .lastInput(lastInput),
    .newBytesProvided(newBytesProvided), .readSuccess(readSuccess),
    .idle(idle), .newBytesRequested(newBytesRequested), .resultReady(resultReady),
    .validOutputBits(validOutputBits), .out(out)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
    logic [31:0] exp_out;
    logic [5:0]  exp_bits;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          max_dly = 0;
  vec_t        vecs[6];
  logic [7:0]  stim_q[$];
  bit          exp_q[$];
  logic [31:0] w_data[$];
  logic [2:0]  w_cnt[$];
  logic        w_last[$];
  logic [31:0] got_w[$];
  logic [5:0]  got_n[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int dly();
    return (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
  endfunction

  task automatic model_emit(input bit v, input longint cnt);
    exp_q.push_back(v);
    for (longint i = 0; i < cnt; i++) exp_q.push_back(!v);
  endtask

  // Reference coder written straight from the algorithm with integer arithmetic.
  task automatic model();
    longint a, b, s, w;
    int     sym, n;
    bit     go;
    exp_q.delete();
    a = 0; b = 32768; s = 0; n = stim_q.size();
    for (int i = 0; i <= n; i++) begin
      sym = (i < n) ? int'(stim_q[i]) : 256;
      w = b - a;
      b = a + (w * (sym + 1)) / 257;
      a = a + (w * sym) / 257;
      go = 1'b1;
      while (go) begin
        if (b < 16384) begin
          model_emit(1'b0, s); s = 0; a = 2 * a; b = 2 * b;
        end else if (a > 16384) begin
          model_emit(1'b1, s); s = 0; a = 2 * (a - 16384); b = 2 * (b - 16384);
        end else if (a > 8192 && b < 24576) begin
          s++; a = 2 * (a - 8192); b = 2 * (b - 8192);
        end else go = 1'b0;
      end
    end
    s++;
    if (a <= 8192) model_emit(1'b0, s); else model_emit(1'b1, s);
  endtask

  task automatic build_words();
    int n, i, c;
    logic [31:0] d;
    w_data.delete(); w_cnt.delete(); w_last.delete();
    n = stim_q.size(); i = 0;
    do begin
      d = '0; c = 0;
      for (int j = 0; j < 4; j++)
        if (i + j < n) begin d[8*j +: 8] = stim_q[i + j]; c++; end
      w_data.push_back(d); w_cnt.push_back(3'(c)); w_last.push_back(i + 4 >= n);
      i += 4;
    end while (i < n);
  endtask

  task automatic drive_word(input int idx);
    inputBytes = w_data[idx]; validInputBytes = w_cnt[idx]; lastInput = w_last[idx];
  endtask

  task automatic run_dut();
    int widx, budget, guard;
    got_w.delete(); got_n.delete();
    @(negedge clk);
    drive_word(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_start", idle, 0);
    widx = 1; budget = 0;
    while (!idle && budget < 40000) begin
      if (resultReady) begin
        repeat (dly()) @(negedge clk);
        got_w.push_back(out); got_n.push_back(validOutputBits);
        readSuccess = 1'b1; guard = 0;
        while (resultReady && guard < 50) begin @(negedge clk); guard++; end
        readSuccess = 1'b0;
      end else if (newBytesRequested) begin
        repeat (dly()) @(negedge clk);
        if (widx < w_data.size()) begin
          drive_word(widx);
        end else begin
          check("extra_request", 32'(widx), 32'(w_data.size() - 1));
          inputBytes = '0; validInputBytes = '0; lastInput = 1'b1;
        end
        widx++;
        newBytesProvided = 1'b1; guard = 0;
        while (newBytesRequested && guard < 50) begin @(negedge clk); guard++; end
        newBytesProvided = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    check("run_completes", idle, 1);
    check("words_consumed", 32'(widx), 32'(w_data.size()));
  endtask

  task automatic compare_model(input string tag);
    int nw, nb;
    logic [31:0] ew;
    model();
    nw = (exp_q.size() + 31) / 32;
    check({tag, "_nwords"}, 32'(got_w.size()), 32'(nw));
    for (int k = 0; k < nw && k < got_w.size(); k++) begin
      nb = (exp_q.size() - 32 * k < 32) ? exp_q.size() - 32 * k : 32;
      ew = '0;
      for (int j = 0; j < nb; j++) ew[j] = exp_q[32 * k + j];
      check({tag, "_word"}, got_w[k], ew);
      check({tag, "_bits"}, 32'(got_n[k]), 32'(nb));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_ready"}, resultReady, 0);
    check({tag, "_req"}, newBytesRequested, 0);
    check({tag, "_valid"}, 32'(validOutputBits), 0);
    check({tag, "_out"}, out, 0);
  endtask

  task automatic set_single(input logic [31:0] d, input logic [2:0] c);
    w_data.delete(); w_cnt.delete(); w_last.delete();
    w_data.push_back(d); w_cnt.push_back(c); w_last.push_back(1'b1);
  endtask

  initial begin
    int found, guard;
    logic [31:0] first_w;
    vecs[0] = '{32'h0000_0000, 3'd0, 32'h0000_00FF, 6'd9};
    vecs[1] = '{32'hDEAD_BEEF, 3'd0, 32'h0000_00FF, 6'd9};
    vecs[2] = '{32'h0000_0000, 3'd1, 32'h0001_BF00, 6'd17};
    vecs[3] = '{32'hABCD_EF00, 3'd1, 32'h0001_BF00, 6'd17};
    vecs[4] = '{32'h0000_00FF, 3'd1, 32'h0000_FF7F, 6'd16};
    vecs[5] = '{32'h1234_56FF, 3'd1, 32'h0000_FF7F, 6'd16};

    rstn = 1'b0; start = 1'b0; inputBytes = '0; validInputBytes = '0; lastInput = 1'b0;
    newBytesProvided = 1'b0; readSuccess = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    max_dly = 3;
    for (int v = 0; v < 6; v++) begin
      set_single(vecs[v].data, vecs[v].cnt);
      run_dut();
      check("vec_nwords", 32'(got_w.size()), 1);
      first_w = (got_w.size() > 0) ? got_w[0] : 32'hDEAD_DEAD;
      check("vec_out", first_w, vecs[v].exp_out);
      check("vec_bits", (got_n.size() > 0) ? 32'(got_n[0]) : 32'hFF, 32'(vecs[v].exp_bits));
    end

    // Count above 4 codes exactly four bytes.
    set_single(32'h0403_0201, 3'd7);
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_dut();
    compare_model("clamp");

    // Zero-byte words in the middle of a stream are skipped.
    w_data = '{32'h0, 32'h0000_AA55, 32'hFFFF_FFFF, 32'h0033_2211};
    w_cnt  = '{3'd0, 3'd2, 3'd0, 3'd3};
    w_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    stim_q = '{8'h55, 8'hAA, 8'h11, 8'h22, 8'h33};
    run_dut();
    compare_model("zero_words");

    // Streaming with random handshake delays.
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(8'($urandom_range(255, 0)));
    build_words();
    max_dly = 20;
    run_dut();
    compare_model("stream");

    // Stream whose code length is a whole number of words.
    max_dly = 2; found = 0;
    for (int t = 0; t < 2000 && found == 0; t++) begin
      stim_q.delete();
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) stim_q.push_back(8'($urandom_range(255, 0)));
      model();
      if (exp_q.size() % 32 == 0) found = 1;
    end
    check("exact_found", 32'(found), 1);
    build_words();
    run_dut();
    compare_model("exact");
    repeat (5) @(negedge clk);
    check("exact_no_extra_ready", resultReady, 0);
    check("exact_idle", idle, 1);

    // Asynchronous reset while the dividers are running.
    set_single(32'h0, 3'd0);
    @(negedge clk);
    drive_word(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("div_busy", idle, 0);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("rst_div");
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset while a word is being offered.
    set_single(32'h0, 3'd1);
    @(negedge clk);
    drive_word(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!resultReady && guard < 2000) begin @(negedge clk); guard++; end
    check("pre_rst_ready", resultReady, 1);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("rst_ready");
    @(negedge clk);
    rstn = 1'b1;

    set_single(32'h0, 3'd0);
    run_dut();
    check("post_rst_out", (got_w.size() > 0) ? got_w[0] : 32'hDEAD_DEAD, 32'h0000_00FF);
    check("post_rst_bits", (got_n.size() > 0) ? 32'(got_n[0]) : 32'hFF, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
